// File: rtl/pipelined_control_unit.sv
// Decode/control stage: turns an opcode into ALU/memory/jump/write-back controls held in a valid/ready register.
// Latency: one cycle from accept to out_valid; one instruction per cycle when out_ready stays high and no hazard.
// Backpressure: in_ready drops on flush, load-use hazard, or a held bundle with out_ready low; a hazard inserts one bubble.
module pipelined_control_unit #(
  parameter int OP_CODE_BITS  = 6,
  parameter int ALU_OP_BITS   = 4,
  parameter int MEM_OP_BITS   = 2,
  parameter int JUMP_BITS     = 4,
  parameter int REG_ADDR_BITS = 5,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_CODE_BITS-1:0]  opcode,
  input  logic [REG_ADDR_BITS-1:0] rs,
  input  logic [REG_ADDR_BITS-1:0] rt,
  input  logic [REG_ADDR_BITS-1:0] rd,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALU_OP_BITS-1:0]   alu_op,
  output logic                     alu_src,
  output logic [MEM_OP_BITS-1:0]   mem_op,
  output logic                     mem_to_reg,
  output logic                     address_src,
  output logic [JUMP_BITS-1:0]     jop,
  output logic                     reg_write,
  output logic [REG_ADDR_BITS-1:0] dst,
  output logic [CNT_BITS-1:0]      bubble_count
);

  localparam logic [MEM_OP_BITS-1:0] MEM_NOP   = MEM_OP_BITS'(0);
  localparam logic [MEM_OP_BITS-1:0] MEM_READ  = MEM_OP_BITS'(1);
  localparam logic [MEM_OP_BITS-1:0] MEM_WRITE = MEM_OP_BITS'(2);

  logic [1:0] op_class;
  logic [3:0] sub_op;

  logic [ALU_OP_BITS-1:0]   dec_alu_op;
  logic                     dec_alu_src;
  logic [MEM_OP_BITS-1:0]   dec_mem_op;
  logic                     dec_mem_to_reg;
  logic                     dec_address_src;
  logic [JUMP_BITS-1:0]     dec_jop;
  logic                     dec_reg_write;
  logic [REG_ADDR_BITS-1:0] dec_dst;
  logic                     dec_uses_rs;
  logic                     dec_uses_rt;

  logic                     hazard;

  logic                     out_valid_q, out_valid_d;
  logic [ALU_OP_BITS-1:0]   alu_op_q, alu_op_d;
  logic                     alu_src_q, alu_src_d;
  logic [MEM_OP_BITS-1:0]   mem_op_q, mem_op_d;
  logic                     mem_to_reg_q, mem_to_reg_d;
  logic                     address_src_q, address_src_d;
  logic [JUMP_BITS-1:0]     jop_q, jop_d;
  logic                     reg_write_q, reg_write_d;
  logic [REG_ADDR_BITS-1:0] dst_q, dst_d;
  logic [CNT_BITS-1:0]      bubble_count_q, bubble_count_d;

  assign op_class = opcode[OP_CODE_BITS-1 -: 2];
  assign sub_op   = opcode[3:0];

  // Decode the incoming opcode into a control bundle plus which source fields it reads.
  always_comb begin
    dec_alu_op      = '0;
    dec_alu_src     = 1'b0;
    dec_mem_op      = MEM_NOP;
    dec_mem_to_reg  = 1'b0;
    dec_address_src = 1'b0;
    dec_jop         = '0;
    dec_reg_write   = 1'b0;
    dec_dst         = rt;
    dec_uses_rs     = 1'b0;
    dec_uses_rt     = 1'b0;
    case (op_class)
      2'b00: begin
        dec_alu_op    = ALU_OP_BITS'(sub_op);
        dec_reg_write = 1'b1;
        dec_dst       = rd;
        dec_uses_rs   = 1'b1;
        dec_uses_rt   = 1'b1;
      end
      2'b01: begin
        dec_alu_op    = ALU_OP_BITS'(sub_op);
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_uses_rs   = 1'b1;
      end
      2'b10: begin
        dec_uses_rs = 1'b1;
        case (sub_op)
          4'd0, 4'd2: begin
            dec_mem_op     = MEM_READ;
            dec_mem_to_reg = 1'b1;
            dec_reg_write  = 1'b1;
          end
          4'd1, 4'd3: begin
            dec_mem_op  = MEM_WRITE;
            dec_uses_rt = 1'b1;
          end
          default: dec_mem_op = MEM_NOP;
        endcase
        dec_address_src = (sub_op == 4'd2) || (sub_op == 4'd3);
      end
      default: begin
        if (sub_op < 4'd10) dec_jop = JUMP_BITS'(sub_op) + JUMP_BITS'(1);
      end
    endcase
  end

  // Load-use hazard: a held load whose destination feeds a source of the incoming instruction.
  always_comb begin
    hazard = 1'b0;
    if (in_valid && out_valid_q && (mem_op_q == MEM_READ) && (dst_q != '0))
      hazard = (dec_uses_rs && (dst_q == rs)) || (dec_uses_rt && (dst_q == rt));
  end

  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);

  // Next pipeline-register contents: flush beats accept, which beats bubble, consume and hold.
  always_comb begin
    out_valid_d    = out_valid_q;
    alu_op_d       = alu_op_q;
    alu_src_d      = alu_src_q;
    mem_op_d       = mem_op_q;
    mem_to_reg_d   = mem_to_reg_q;
    address_src_d  = address_src_q;
    jop_d          = jop_q;
    reg_write_d    = reg_write_q;
    dst_d          = dst_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid_d   = 1'b1;
      alu_op_d      = dec_alu_op;
      alu_src_d     = dec_alu_src;
      mem_op_d      = dec_mem_op;
      mem_to_reg_d  = dec_mem_to_reg;
      address_src_d = dec_address_src;
      jop_d         = dec_jop;
      reg_write_d   = dec_reg_write;
      dst_d         = dec_dst;
    end else if (hazard && out_ready) begin
      out_valid_d = 1'b0;
      if (bubble_count_q != '1) bubble_count_d = bubble_count_q + CNT_BITS'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline register and bubble counter; reset clears everything, including a stalled load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      alu_op_q       <= '0;
      alu_src_q      <= 1'b0;
      mem_op_q       <= '0;
      mem_to_reg_q   <= 1'b0;
      address_src_q  <= 1'b0;
      jop_q          <= '0;
      reg_write_q    <= 1'b0;
      dst_q          <= '0;
      bubble_count_q <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      alu_op_q       <= alu_op_d;
      alu_src_q      <= alu_src_d;
      mem_op_q       <= mem_op_d;
      mem_to_reg_q   <= mem_to_reg_d;
      address_src_q  <= address_src_d;
      jop_q          <= jop_d;
      reg_write_q    <= reg_write_d;
      dst_q          <= dst_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_op       = alu_op_q;
  assign alu_src      = alu_src_q;
  assign mem_op       = mem_op_q;
  assign mem_to_reg   = mem_to_reg_q;
  assign address_src  = address_src_q;
  assign jop          = jop_q;
  assign reg_write    = reg_write_q;
  assign dst          = dst_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Parametrised, registered decode/control stage sitting between instruction fetch and execute. It decodes an opcode into ALU, memory, jump and write-back controls and holds them in a valid/ready pipeline register. It also detects load-use hazards against the instruction it currently holds and inserts a one-cycle bubble. It supports a synchronous flush for taken jumps and keeps a saturating bubble counter.

## Interface
- OP_CODE_BITS, 6, opcode width; the class is opcode[top:top-1], the sub-op is opcode[3:0]
- ALU_OP_BITS, 4, ALU operation width
- MEM_OP_BITS, 2, memory op width: 0 NOP, 1 READ, 2 WRITE
- JUMP_BITS, 4, jump op width: 0 NOP, 1..10 = J, JEQ, JNE, JL, JLE, JG, JGE, JZ, JNZ, JO
- REG_ADDR_BITS, 5, register index width
- CNT_BITS, 16, bubble counter width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  the opcode, rs, rt and rd fields are valid
- in_ready  out  1  stage accepts input this cycle
- opcode  in  OP_CODE_BITS  instruction opcode
- rs, rt, rd  in  REG_ADDR_BITS each  source/destination fields
- flush  in  1  kill the held instruction and drop this cycle's input
- out_valid  out  1  control bundle valid
- out_ready  in  1  execute stage consumes the bundle
- alu_op  out  ALU_OP_BITS  registered
- alu_src  out  1  registered; 1 = immediate operand
- mem_op  out  MEM_OP_BITS  registered
- mem_to_reg  out  1  registered
- address_src  out  1  registered; 1 = absolute address (LA/SA)
- jop  out  JUMP_BITS  registered
- reg_write  out  1  registered
- dst  out  REG_ADDR_BITS  registered write-back register (rd if reg-class, else rt)
- bubble_count  out  CNT_BITS  saturating count of inserted bubbles

## Operation
- Decode by class:
  - 00: reg ALU. alu_op = opcode[3:0], alu_src = 0, reg_write = 1, dst = rd; uses rs and rt.
  - 01: immediate ALU. alu_op = opcode[3:0], alu_src = 1, reg_write = 1, dst = rt; uses rs only.
  - 10: memory. Sub-op 0 LW, 1 SW, 2 LA, 3 SA.
    - LW/LA: mem_op = READ, mem_to_reg = 1, reg_write = 1.
    - SW/SA: mem_op = WRITE, reg_write = 0, and rt is also used.
    - address_src = 1 for LA/SA only.
    - Sub-ops 4..15: mem_op = NOP, reg_write = 0.
  - 11: jump. Sub-op k in 0..9 gives jop = k+1; 10..15 give jop = 0. reg_write = 0; uses no sources.
- Every field not listed for a class is 0.
- Hazard: out_valid, out mem_op == READ, dst != 0, and (dst == rs, or (rt is used and dst == rt)), evaluated on the incoming instruction.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): the decoded bundle loads and out_valid = 1.
- Consume without accept: out_valid = 0.
- Hazard with out_ready: the held load leaves, the register becomes a bubble (out_valid = 0), and bubble_count increments unless it is all-ones.
- Hazard without out_ready: everything holds.
- flush: out_valid = 0 next cycle and the input is not accepted. Flush takes priority over accept, hazard and counting.

## Timing
- Reset (async assert): out_valid 0, all control outputs 0, dst 0, bubble_count 0. in_ready follows its equation (1 while flush = 0).
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle with out_ready held high and no hazards.
- A load-use pair costs exactly one bubble cycle.
- Outputs hold stable while out_valid && !out_ready.
- in_ready is combinational from the inputs and the held state. No combinational path exists from in_valid to out_*.
- Reset mid-stall or mid-bubble drops the held instruction; no state survives.

## Test plan
- Reset then stream ADD(000000, rd = 3), ADDI(010000, rt = 4), JE(110001) with out_ready = 1 -> outputs one cycle later:
  - ADD: alu_op 0, alu_src 0, reg_write 1, dst 3.
  - ADDI: alu_src 1, dst 4.
  - JE: jop 2, reg_write 0.
  - No bubbles.
- LW(100000, rt = 5) then ADD(rs = 5) -> in_ready = 0 for one cycle, one bubble, bubble_count = 1, ADD appears two cycles after LW.
- Load-use cases with no hazard:
  - LW(rt = 0) then ADD(rs = 0) -> no bubble.
  - LW(rt = 5) then ADDI(rt = 5, rs = 2) -> no bubble (rt unused).
- LW held with out_ready = 0 for 3 cycles and ADD(rs = 5) waiting -> outputs stable, count unchanged; when out_ready rises -> bubble, then ADD.
- flush with a valid held bundle and in_valid = 1 -> out_valid = 0 next cycle, input dropped, count unchanged.
- Preload many load-use pairs with CNT_BITS = 2 -> counter saturates at 3. Assert rst_n low mid-run -> all outputs 0 immediately.
